// File: rtl/dir_input_ctrl.sv
// dir_input_ctrl: synchronised, debounced multi-key front end whose direction presses
// are validated and queued, then committed one per game step.
module dir_input_ctrl #(
    parameter int               NUM_KEYS       = 4,
    parameter int               CNT_W          = 20,
    parameter logic [CNT_W-1:0] CNT_MAX        = 20'd499_999,
    parameter int               QDEPTH         = 4,
    parameter bit               KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_KEYS-1:0]       key_in,
    input  logic                      move_tick,
    input  logic                      clr,
    output logic [NUM_KEYS-1:0]       key_level,
    output logic [NUM_KEYS-1:0]       key_flag,
    output logic [1:0]                dir_out,
    output logic                      dir_update,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      q_overflow
);

    localparam int                  PTR_W        = $clog2(QDEPTH);
    localparam int                  CQ_W         = PTR_W + 1;
    localparam logic [NUM_KEYS-1:0] RELEASED_RAW = {NUM_KEYS{KEY_ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]    CNT_ONE      = CNT_W'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE      = PTR_W'(1);
    localparam logic [CQ_W-1:0]     CQ_ONE       = CQ_W'(1);
    localparam logic [CQ_W-1:0]     CQ_FULL      = CQ_W'(QDEPTH);

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] stable_r;
    logic [NUM_KEYS-1:0] stable_d_r;
    logic [NUM_KEYS-1:0] flag_r;
    logic [CNT_W-1:0]    cnt_r [NUM_KEYS];
    logic [NUM_KEYS-1:0] pressed_s;

    logic [1:0]          q_mem_r [QDEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CQ_W-1:0]     count_r;
    logic [1:0]          dir_r;
    logic                update_r;
    logic                ovf_r;

    logic                cand_valid_s;
    logic [1:0]          cand_dir_s;
    logic [1:0]          ref_dir_s;
    logic                valid_s;
    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;

    // Synchronised raw level normalised so that 1 means pressed.
    assign pressed_s = sync2_r ^ RELEASED_RAW;

    // Synchroniser, per-channel debounce counter and registered press pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r    <= RELEASED_RAW;
            sync2_r    <= RELEASED_RAW;
            stable_r   <= '0;
            stable_d_r <= '0;
            flag_r     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            sync1_r    <= key_in;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            flag_r     <= stable_r & ~stable_d_r;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (pressed_s[k] != stable_r[k]) begin
                    if (cnt_r[k] == CNT_MAX) begin
                        stable_r[k] <= pressed_s[k];
                        cnt_r[k]    <= '0;
                    end else begin
                        cnt_r[k]    <= cnt_r[k] + CNT_ONE;
                    end
                end else begin
                    cnt_r[k] <= '0;
                end
            end
        end
    end

    // Candidate selection (lowest direction index wins) and queue control decode.
    always_comb begin
        cand_valid_s = 1'b1;
        cand_dir_s   = 2'd0;
        if (flag_r[0]) begin
            cand_dir_s = 2'd0;
        end else if (flag_r[1]) begin
            cand_dir_s = 2'd1;
        end else if (flag_r[2]) begin
            cand_dir_s = 2'd2;
        end else if (flag_r[3]) begin
            cand_dir_s = 2'd3;
        end else begin
            cand_valid_s = 1'b0;
        end

        if (count_r != '0) begin
            ref_dir_s = q_mem_r[tail_r - PTR_ONE];
        end else begin
            ref_dir_s = dir_r;
        end

        // Same axis means either a repeat or a reversal; both are rejected.
        valid_s = cand_valid_s && (cand_dir_s[1] != ref_dir_s[1]);
        full_s  = (count_r == CQ_FULL);
        pop_s   = move_tick && (count_r != '0);
        push_s  = valid_s && (!full_s || pop_s);
        drop_s  = valid_s && full_s && !pop_s;
    end

    // Direction queue, committed direction and sticky overflow; clr outranks tick and press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            dir_r    <= 2'd0;
            update_r <= 1'b0;
            ovf_r    <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_mem_r[i] <= 2'd0;
            end
        end else if (clr) begin
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            dir_r    <= 2'd0;
            update_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            update_r <= pop_s;
            if (pop_s) begin
                dir_r  <= q_mem_r[head_r];
                head_r <= head_r + PTR_ONE;
            end
            if (push_s) begin
                q_mem_r[tail_r] <= cand_dir_s;
                tail_r          <= tail_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CQ_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CQ_ONE;
            end else begin
                count_r <= count_r;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign key_level  = stable_r;
    assign key_flag   = flag_r;
    assign dir_out    = dir_r;
    assign dir_update = update_r;
    assign q_count    = count_r;
    assign q_overflow = ovf_r;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Self-checking bench for dir_input_ctrl: directed scenarios plus a randomized run
// checked cycle by cycle against a queue-based behavioural model.
module tb_dir_input_ctrl;

    localparam int NK   = 5;
    localparam int QD   = 4;
    localparam int CMAX = 3;

    localparam logic [NK-1:0] K_RIGHT = 5'b00001;
    localparam logic [NK-1:0] K_LEFT  = 5'b00010;
    localparam logic [NK-1:0] K_DOWN  = 5'b00100;
    localparam logic [NK-1:0] K_UP    = 5'b01000;
    localparam logic [NK-1:0] K_GEN   = 5'b10000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic          move_tick;
    logic          clr;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_flag;
    logic [1:0]    dir_out;
    logic          dir_update;
    logic [2:0]    q_count;
    logic          q_overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state (pressed = 1)
    logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_stable_d = '0, m_flag = '0;
    int            m_run [NK];
    int            mq [$];
    int            m_dir = 0;
    bit            m_upd = 1'b0;
    bit            m_ovf = 1'b0;

    dir_input_ctrl #(
        .NUM_KEYS(NK), .CNT_W(4), .CNT_MAX(4'd3), .QDEPTH(QD), .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .move_tick(move_tick), .clr(clr),
        .key_level(key_level), .key_flag(key_flag), .dir_out(dir_out),
        .dir_update(dir_update), .q_count(q_count), .q_overflow(q_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_keys(input logic [NK-1:0] pressed);
        key_in = ~pressed;
    endtask

    // Apply the rules for one clock edge to the model.
    task automatic model_edge();
        int  cand;
        int  rf;
        bit  valid;
        bit  pop;
        logic [NK-1:0] new_flag;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_stable_d = '0; m_flag = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
            mq.delete(); m_dir = 0; m_upd = 1'b0; m_ovf = 1'b0;
            return;
        end
        if (clr) begin
            mq.delete(); m_dir = 0; m_upd = 1'b0; m_ovf = 1'b0;
        end else begin
            cand = -1;
            for (int i = 3; i >= 0; i--) if (m_flag[i]) cand = i;
            rf    = (mq.size() > 0) ? mq[$] : m_dir;
            valid = (cand >= 0) && (cand != rf) && (cand != (rf ^ 1));
            pop   = move_tick && (mq.size() > 0);
            m_upd = pop;
            if (pop) m_dir = mq.pop_front();
            if (valid) begin
                if (mq.size() < QD) mq.push_back(cand);
                else m_ovf = 1'b1;
            end
        end
        new_flag   = m_stable & ~m_stable_d;
        m_stable_d = m_stable;
        for (int i = 0; i < NK; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == CMAX + 1) begin
                    m_stable[i] = m_s2[i];
                    m_run[i]    = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_flag = new_flag;
        m_s2   = m_s1;
        m_s1   = ~key_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic press(input logic [NK-1:0] mask);
        set_keys(mask);
        repeat (8) cyc();
        set_keys('0);
        repeat (7) cyc();
    endtask

    task automatic tick();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; move_tick = 1'b0; set_keys('0);
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        n_cmp++;
        if ({key_level, key_flag, dir_out, dir_update, q_count, q_overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_state: lvl=%b flg=%b dir=%0d upd=%b q=%0d ovf=%b, want all 0",
                     key_level, key_flag, dir_out, dir_update, q_count, q_overflow);
        end
    endtask

    task automatic test_debounce();
        bit seen;
        set_keys(K_RIGHT);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            n_cmp++;
            if (key_flag[0] !== 1'(i == 7)) begin
                n_err++;
                $display("FAIL debounce_flag cycle %0d: got %b want %b", i, key_flag[0], i == 7);
            end
        end
        n_cmp++;
        if (key_level[0] !== 1'b1 || q_count !== 3'd0) begin
            n_err++;
            $display("FAIL debounce_level: level=%b q=%0d want level=1 q=0", key_level[0], q_count);
        end
        set_keys('0);
        repeat (8) cyc();
        seen = 1'b0;
        set_keys(K_RIGHT);
        repeat (3) cyc();
        set_keys('0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            seen = seen | key_flag[0] | key_level[0];
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_ignored: got activity=%b want 0", seen);
        end
        set_keys(K_GEN);
        repeat (7) cyc();
        n_cmp++;
        if (key_flag !== K_GEN) begin
            n_err++;
            $display("FAIL generic_flag: got %b want %b", key_flag, K_GEN);
        end
        cyc();
        set_keys('0);
        n_cmp++;
        if (q_count !== 3'd0 || key_level[4] !== 1'b1) begin
            n_err++;
            $display("FAIL generic_no_queue: q=%0d level4=%b want q=0 level4=1", q_count, key_level[4]);
        end
        repeat (8) cyc();
    endtask

    task automatic test_reversal();
        do_clr();
        press(K_LEFT);
        n_cmp++;
        if (q_count !== 3'd0) begin n_err++; $display("FAIL reversal_left: q got %0d want 0", q_count); end
        press(K_RIGHT);
        n_cmp++;
        if (q_count !== 3'd0) begin n_err++; $display("FAIL repeat_right: q got %0d want 0", q_count); end
        press(K_UP);
        n_cmp++;
        if (q_count !== 3'd1) begin n_err++; $display("FAIL accept_up: q got %0d want 1", q_count); end
        tick();
        n_cmp++;
        if (dir_out !== 2'd3 || dir_update !== 1'b1 || q_count !== 3'd0) begin
            n_err++;
            $display("FAIL pop_up: dir=%0d upd=%b q=%0d want 3 1 0", dir_out, dir_update, q_count);
        end
        tick();
        n_cmp++;
        if (dir_out !== 2'd3 || dir_update !== 1'b0) begin
            n_err++;
            $display("FAIL empty_tick: dir=%0d upd=%b want 3 0", dir_out, dir_update);
        end
    endtask

    task automatic test_chaining();
        int exp_dir [4] = '{3, 1, 2, 0};
        do_clr();
        press(K_UP); press(K_LEFT); press(K_DOWN); press(K_RIGHT);
        n_cmp++;
        if (q_count !== 3'd4 || q_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL chain_fill: q=%0d ovf=%b want 4 0", q_count, q_overflow);
        end
        press(K_UP);
        n_cmp++;
        if (q_count !== 3'd4 || q_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL chain_overflow: q=%0d ovf=%b want 4 1", q_count, q_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (dir_out !== 2'(exp_dir[i]) || dir_update !== 1'b1 || q_overflow !== 1'b1) begin
                n_err++;
                $display("FAIL chain_pop%0d: dir=%0d upd=%b ovf=%b want %0d 1 1",
                         i, dir_out, dir_update, q_overflow, exp_dir[i]);
            end
            cyc();
        end
    endtask

    task automatic test_simultaneous();
        do_clr();
        press(K_UP | K_DOWN);
        n_cmp++;
        if (q_count !== 3'd1) begin n_err++; $display("FAIL simul_count: q got %0d want 1", q_count); end
        tick();
        n_cmp++;
        if (dir_out !== 2'd2) begin n_err++; $display("FAIL simul_lowest: dir got %0d want 2", dir_out); end
        do_clr();
        press(K_UP); press(K_LEFT); press(K_DOWN); press(K_RIGHT);
        set_keys(K_UP);
        repeat (7) cyc();
        tick();
        set_keys('0);
        n_cmp++;
        if (q_count !== 3'd4 || q_overflow !== 1'b0 || dir_out !== 2'd3 || dir_update !== 1'b1) begin
            n_err++;
            $display("FAIL full_push_pop: q=%0d ovf=%b dir=%0d upd=%b want 4 0 3 1",
                     q_count, q_overflow, dir_out, dir_update);
        end
        repeat (7) cyc();
    endtask

    task automatic test_clr();
        do_clr();
        press(K_UP); press(K_LEFT); press(K_DOWN); press(K_RIGHT); press(K_UP);
        tick();
        n_cmp++;
        if (q_count !== 3'd3 || q_overflow !== 1'b1 || dir_out !== 2'd3) begin
            n_err++;
            $display("FAIL clr_setup: q=%0d ovf=%b dir=%0d want 3 1 3", q_count, q_overflow, dir_out);
        end
        set_keys(K_UP);
        repeat (7) cyc();
        clr = 1'b1; move_tick = 1'b1;
        cyc();
        clr = 1'b0; move_tick = 1'b0;
        n_cmp++;
        if (q_count !== 3'd0 || dir_out !== 2'd0 || q_overflow !== 1'b0 || dir_update !== 1'b0) begin
            n_err++;
            $display("FAIL clr_priority: q=%0d dir=%0d ovf=%b upd=%b want 0 0 0 0",
                     q_count, dir_out, q_overflow, dir_update);
        end
        cyc();
        n_cmp++;
        if (q_count !== 3'd0 || dir_update !== 1'b0 || key_level[3] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_after: q=%0d upd=%b level3=%b want 0 0 1", q_count, dir_update, key_level[3]);
        end
        set_keys('0);
        repeat (8) cyc();
    endtask

    task automatic test_reset_mid();
        set_keys(K_RIGHT);
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_cmp++;
        if ({key_level, key_flag, dir_out, dir_update, q_count, q_overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_state: lvl=%b flg=%b dir=%0d q=%0d want all 0",
                     key_level, key_flag, dir_out, q_count);
        end
        for (int i = 1; i <= 10; i++) begin
            cyc();
            n_cmp++;
            if (key_flag[0] !== 1'(i == 7)) begin
                n_err++;
                $display("FAIL reset_mid_flag cycle %0d: got %b want %b", i, key_flag[0], i == 7);
            end
        end
        set_keys('0);
        repeat (8) cyc();
    endtask

    task automatic test_random();
        int            hold = 0;
        logic [NK-1:0] mask;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                mask = NK'($urandom_range(0, 3) == 0 ? $urandom : (1 << $urandom_range(0, NK - 1)));
                if ($urandom_range(0, 2) == 0) mask = '0;
                set_keys(mask);
                hold = $urandom_range(1, 12);
            end
            hold--;
            move_tick = ($urandom_range(0, 5) == 0);
            clr       = ($urandom_range(0, 249) == 0);
            rst_n     = ($urandom_range(0, 999) != 0);
            cyc();
            n_cmp++;
            if (key_level !== m_stable || key_flag !== m_flag || dir_out !== 2'(m_dir) ||
                dir_update !== m_upd || q_count !== 3'(mq.size()) || q_overflow !== m_ovf) begin
                n_err++;
                $display("FAIL random c%0d: lvl=%b/%b flg=%b/%b dir=%0d/%0d upd=%b/%b q=%0d/%0d ovf=%b/%b (got/want)",
                         c, key_level, m_stable, key_flag, m_flag, dir_out, m_dir,
                         dir_update, m_upd, q_count, mq.size(), q_overflow, m_ovf);
            end
        end
        move_tick = 1'b0; clr = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; move_tick = 1'b0; set_keys('0);
        test_reset();
        test_debounce();
        test_reversal();
        test_chaining();
        test_simultaneous();
        test_clr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
